// File: rtl/vga_fb_fetch_arbiter.sv
// Framebuffer RAM port controller: raster prefetch into a FWFT FIFO for the VGA
// scan-out, sharing the single RAM port with CPU pixel writes.
module vga_fb_fetch_arbiter #(
    parameter int H_ACTIVE   = 640,
    parameter int V_ACTIVE   = 480,
    parameter int ADDR_W     = 19,
    parameter int DATA_W     = 12,
    parameter int FIFO_DEPTH = 8
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              frame_start,
    input  logic              pixel_req,
    output logic              pixel_valid,
    output logic [DATA_W-1:0] pixel_data,
    output logic              underflow,
    input  logic              cpu_valid,
    input  logic [ADDR_W-1:0] cpu_addr,
    input  logic [DATA_W-1:0] cpu_wdata,
    output logic              cpu_ready,
    output logic              ram_en,
    output logic              ram_we,
    output logic [ADDR_W-1:0] ram_addr,
    output logic [DATA_W-1:0] ram_wdata,
    input  logic [DATA_W-1:0] ram_rdata
);
    localparam int PIX   = H_ACTIVE * V_ACTIVE;
    localparam int PTR_W = $clog2(FIFO_DEPTH);
    localparam int CNT_W = PTR_W + 1;
    localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(PIX - 1);
    localparam logic [ADDR_W:0]   PIX_END   = (ADDR_W+1)'(PIX);
    localparam logic [CNT_W:0]    DEPTH     = (CNT_W+1)'(FIFO_DEPTH);
    localparam logic [CNT_W:0]    HALF      = (CNT_W+1)'(FIFO_DEPTH / 2);

    typedef enum logic [1:0] {S_IDLE, S_FETCH, S_DONE} state_t;

    state_t              state, state_nxt;
    logic                fetching;
    logic [ADDR_W-1:0]   fetch_addr;
    logic [DATA_W-1:0]   fifo_mem [FIFO_DEPTH];
    logic [PTR_W-1:0]    rd_ptr, wr_ptr;
    logic [CNT_W-1:0]    count;
    logic                inflight;
    logic [CNT_W:0]      occ;
    logic                fetch_ok, urgent, cpu_in_range;
    logic                grant_fetch, grant_cpu, cpu_wr;
    logic                push, pop;

    assign occ          = {1'b0, count} + (CNT_W+1)'(inflight);
    assign fetch_ok     = fetching && (occ < DEPTH) && !frame_start;
    assign urgent       = occ < HALF;
    assign cpu_in_range = {1'b0, cpu_addr} < PIX_END;

    // Priority flips with occupancy: display refill first when running low.
    always_comb begin
        grant_fetch = 1'b0;
        grant_cpu   = 1'b0;
        if (!rst) begin
            if (urgent) begin
                if (fetch_ok)       grant_fetch = 1'b1;
                else if (cpu_valid) grant_cpu   = 1'b1;
            end else begin
                if (cpu_valid)      grant_cpu   = 1'b1;
                else if (fetch_ok)  grant_fetch = 1'b1;
            end
        end
    end

    assign cpu_wr    = grant_cpu && cpu_in_range;
    assign cpu_ready = grant_cpu;
    assign ram_en    = grant_fetch || cpu_wr;
    assign ram_we    = cpu_wr;
    assign ram_addr  = cpu_wr ? cpu_addr : (grant_fetch ? fetch_addr : '0);
    assign ram_wdata = cpu_wr ? cpu_wdata : '0;

    // A read returning in the frame_start cycle belongs to the old frame.
    assign push        = inflight && !frame_start;
    assign pixel_valid = (count != '0);
    assign pop         = pixel_req && pixel_valid && !frame_start;
    assign pixel_data  = pixel_valid ? fifo_mem[rd_ptr] : '0;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= S_IDLE;
        else     state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        if (frame_start)
            state_nxt = S_FETCH;
        else if (state == S_FETCH && grant_fetch && fetch_addr == LAST_ADDR)
            state_nxt = S_DONE;
    end

    always_comb begin
        fetching = (state == S_FETCH);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            count      <= '0;
            rd_ptr     <= '0;
            wr_ptr     <= '0;
            inflight   <= 1'b0;
            underflow  <= 1'b0;
            fetch_addr <= '0;
        end else if (frame_start) begin
            count      <= '0;
            rd_ptr     <= '0;
            wr_ptr     <= '0;
            inflight   <= 1'b0;
            underflow  <= 1'b0;
            fetch_addr <= '0;
        end else begin
            inflight <= grant_fetch;
            count    <= count + CNT_W'(push) - CNT_W'(pop);
            if (push)        wr_ptr     <= wr_ptr + 1'b1;
            if (pop)         rd_ptr     <= rd_ptr + 1'b1;
            if (grant_fetch) fetch_addr <= fetch_addr + 1'b1;
            if (pixel_req && !pixel_valid) underflow <= 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (push) fifo_mem[wr_ptr] <= ram_rdata;
    end

endmodule
